// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: funct3 codes, FSM
// states, beat selection and the per-access beat plan produced by the aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_e;

    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } beat_sel_e;

    // A split access uses both words; an aligned access only be0/wdata0.
    typedef struct packed {
        logic        split;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
    } beat_plan_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte mask of the access size, before shifting by the address offset.
    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_sequencer_if.sv
// Core-side request/response bundle and memory-bus bundle of the sequencer.
interface lsu_core_if;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic        lsu_err;
    logic [31:0] lsu_rdata;

    modport slave (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_done, lsu_err, lsu_rdata
    );

    modport master (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_done, lsu_err, lsu_rdata
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: beat masks and write data for an access, and
// reassembly plus sign/zero extension of the returned load words.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    output beat_plan_t  plan,
    output logic [31:0] load_data
);

    logic [7:0]  mask8;
    logic [63:0] wr_cat;
    logic [63:0] rd_cat;
    logic [31:0] rd_shift;

    assign mask8  = size_mask(funct3) << off;
    assign wr_cat = {32'b0, wdata} << {off, 3'b000};
    assign rd_cat = {beat1, beat0};

    assign plan.split  = |mask8[7:4];
    assign plan.be0    = mask8[3:0];
    assign plan.be1    = mask8[7:4];
    assign plan.wdata0 = wr_cat[31:0];
    assign plan.wdata1 = wr_cat[63:32];

    // Result byte gi comes from byte (gi + off) of the two-word window.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0] byte_idx;
            assign byte_idx = 3'(gi) + {1'b0, off};
            assign rd_shift[8*gi +: 8] = rd_cat[{byte_idx, 3'b000} +: 8];
        end
    endgenerate

    always_comb begin
        load_data = rd_shift;
        case (funct3)
            F3_B:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   load_data = {24'b0, rd_shift[7:0]};
            F3_HU:   load_data = {16'b0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer: registers one core request, issues one or
// two word beats on the memory bus and returns extended load data with done.
module lsu_sequencer
    import lsu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    lsu_core_if.slave core,
    lsu_mem_if.master mem
);

    lsu_state_e  state_reg, state_next;
    beat_sel_e   beat_reg;
    logic        we_reg;
    logic        err_reg;
    logic [2:0]  f3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] beat0_reg;
    logic [31:0] rdata_reg;

    logic        req_legal;
    logic        last_beat;
    beat_plan_t  plan;
    logic [31:0] beat0_in;
    logic [31:0] beat1_in;
    logic [31:0] load_data;
    logic [31:0] word_addr;

    assign req_legal = f3_legal(core.lsu_we, core.lsu_funct3);
    assign word_addr = {addr_reg[31:2], 2'b00};
    assign last_beat = ~(plan.split && (beat_reg == BEAT0));

    // On the final response the live bus word feeds the aligner directly so
    // the extended result can be registered in the same cycle.
    assign beat0_in = (beat_reg == BEAT1) ? beat0_reg : mem.mem_rdata;
    assign beat1_in = (beat_reg == BEAT1) ? mem.mem_rdata : 32'b0;

    lsu_align u_align (
        .funct3    (f3_reg),
        .off       (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .beat0     (beat0_in),
        .beat1     (beat1_in),
        .plan      (plan),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (core.lsu_valid) begin
                    state_next = req_legal ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (mem.mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_next = last_beat ? DONE : ISSUE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg  <= BEAT0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            f3_reg    <= 3'b0;
            addr_reg  <= 32'b0;
            wdata_reg <= 32'b0;
            beat0_reg <= 32'b0;
            rdata_reg <= 32'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (core.lsu_valid) begin
                        beat_reg  <= BEAT0;
                        we_reg    <= core.lsu_we;
                        f3_reg    <= core.lsu_funct3;
                        addr_reg  <= core.lsu_addr;
                        wdata_reg <= core.lsu_wdata;
                        err_reg   <= ~req_legal;
                        if (!req_legal) begin
                            rdata_reg <= 32'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (beat_reg == BEAT0) begin
                            beat0_reg <= mem.mem_rdata;
                        end
                        if (last_beat) begin
                            rdata_reg <= we_reg ? 32'b0 : load_data;
                        end else begin
                            beat_reg <= BEAT1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus fields are only driven while a beat is being offered.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'b0;
        mem.mem_be    = 4'b0;
        mem.mem_wdata = 32'b0;
        if (state_reg == ISSUE) begin
            mem.mem_req = 1'b1;
            mem.mem_we  = we_reg;
            if (beat_reg == BEAT1) begin
                mem.mem_addr  = word_addr + 32'd4;
                mem.mem_be    = plan.be1;
                mem.mem_wdata = plan.wdata1;
            end else begin
                mem.mem_addr  = word_addr;
                mem.mem_be    = plan.be0;
                mem.mem_wdata = plan.wdata0;
            end
        end
    end

    assign core.lsu_ready = (state_reg == IDLE);
    assign core.lsu_done  = (state_reg == DONE);
    assign core.lsu_err   = (state_reg == DONE) && err_reg;
    assign core.lsu_rdata = rdata_reg;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: directed requests push expected beats and
// completions; a negedge monitor grants/responds on the bus and compares.
module tb_lsu_sequencer;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        string       name;
        logic        err;
        logic        chk_rdata;
        logic [31:0] rdata;
        int          lat;
        int          c0;
    } cmpl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_core_if core();
    lsu_mem_if  mem();

    lsu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core),
        .mem   (mem)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_c0  = 0;
    int stall_cnt = 0;

    beat_t       exp_beats[$];
    cmpl_t       exp_done[$];
    logic [31:0] resp_words[$];
    int          resp_delays[$];

    bit          resp_pending = 0;
    int          resp_cnt = 0;
    logic [31:0] resp_word = 32'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Completion monitor and bus responder, both evaluated mid-cycle.
    always @(negedge clk) begin : monitor
        beat_t b;
        cmpl_t e;
        if (core.lsu_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 required no completion");
            end else begin
                e = exp_done.pop_front();
                check({e.name, "_err"}, 32'(core.lsu_err), 32'(e.err));
                if (e.chk_rdata) check({e.name, "_rdata"}, core.lsu_rdata, e.rdata);
                check({e.name, "_latency"}, 32'(cyc - e.c0), 32'(e.lat));
                $display("txn %s: done after %0d cycles err=%0d rdata=%h",
                         e.name, cyc - e.c0, core.lsu_err, core.lsu_rdata);
            end
        end

        mem.mem_rvalid = 1'b0;
        if (resp_pending) begin
            if (resp_cnt == 0) begin
                mem.mem_rvalid = 1'b1;
                mem.mem_rdata  = resp_word;
                resp_pending   = 0;
            end else begin
                resp_cnt--;
            end
        end

        mem.mem_gnt = 1'b0;
        if (mem.mem_req === 1'b1 && rst_n) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (exp_beats.size() > 0) begin
                    check("stall_addr_stable", mem.mem_addr, exp_beats[0].addr);
                    check("stall_be_stable", 32'(mem.mem_be), 32'(exp_beats[0].be));
                end
            end else begin
                mem.mem_gnt = 1'b1;
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got req addr=%h required no bus request", mem.mem_addr);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_addr", mem.mem_addr, b.addr);
                    check("beat_be", 32'(mem.mem_be), 32'(b.be));
                    check("beat_we", 32'(mem.mem_we), 32'(b.we));
                    check("beat_wdata", mem.mem_wdata, b.wdata);
                    $display("beat addr=%h be=%b we=%0d wdata=%h", mem.mem_addr, mem.mem_be, mem.mem_we, mem.mem_wdata);
                end
                resp_pending = 1;
                resp_word    = (resp_words.size() > 0) ? resp_words.pop_front() : 32'b0;
                resp_cnt     = (resp_delays.size() > 0) ? resp_delays.pop_front() : 0;
            end
        end
    end

    task automatic push_beat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                             input logic [31:0] wdata, input logic [31:0] rword, input int delay);
        beat_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
        exp_beats.push_back(b);
        resp_words.push_back(rword);
        resp_delays.push_back(delay);
    endtask

    // lat == 0 means no completion is expected (request aborted by reset).
    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic err, input logic [31:0] rdata, input logic chk, input int lat);
        cmpl_t e;
        for (int k = 0; k < 30 && core.lsu_ready !== 1'b1; k++) @(negedge clk);
        check({name, "_ready"}, 32'(core.lsu_ready), 32'd1);
        core.lsu_valid  = 1'b1;
        core.lsu_we     = we;
        core.lsu_funct3 = f3;
        core.lsu_addr   = addr;
        core.lsu_wdata  = wdata;
        last_c0 = cyc;
        if (lat > 0) begin
            e.name = name; e.err = err; e.chk_rdata = chk; e.rdata = rdata; e.lat = lat; e.c0 = cyc;
            exp_done.push_back(e);
        end
        @(negedge clk);
        core.lsu_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 60; k++) begin
            if (exp_done.size() == 0 && exp_beats.size() == 0 && !resp_pending) break;
            @(negedge clk);
        end
        n_checks++;
        if (k == 60) begin
            n_fail++;
            $display("FAIL %s_timeout: got pending=%0d/%0d required all drained",
                     name, exp_done.size(), exp_beats.size());
            exp_done.delete();
            exp_beats.delete();
            resp_words.delete();
            resp_delays.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        core.lsu_valid = 1'b0; core.lsu_we = 1'b0; core.lsu_funct3 = 3'b0;
        core.lsu_addr = 32'b0; core.lsu_wdata = 32'b0;
        mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(core.lsu_ready), 32'd1);
        check("rst_done", 32'(core.lsu_done), 32'd0);
        check("rst_err", 32'(core.lsu_err), 32'd0);
        check("rst_rdata", core.lsu_rdata, 32'd0);
        check("rst_req", 32'(mem.mem_req), 32'd0);
        check("rst_we", 32'(mem.mem_we), 32'd0);
        check("rst_be", 32'(mem.mem_be), 32'd0);
        check("rst_addr", mem.mem_addr, 32'd0);
        check("rst_wdata", mem.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0);
        do_req("lw_aligned", 1'b0, F3_W, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 3);
        wait_idle("lw_aligned");

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
        do_req("lb_sext", 1'b0, F3_B, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1, 3);
        wait_idle("lb_sext");

        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
        do_req("lbu_zext", 1'b0, F3_BU, 32'h103, 32'h0, 1'b0, 32'h00000080, 1'b1, 3);
        wait_idle("lbu_zext");

        push_beat(32'h400, 4'b1100, 1'b0, 32'h0, 32'h80011234, 0);
        do_req("lhu_hi", 1'b0, F3_HU, 32'h402, 32'h0, 1'b0, 32'h00008001, 1'b1, 3);
        wait_idle("lhu_hi");

        push_beat(32'h400, 4'b1100, 1'b0, 32'h0, 32'h80011234, 0);
        do_req("lh_hi", 1'b0, F3_H, 32'h402, 32'h0, 1'b0, 32'hFFFF8001, 1'b1, 3);
        wait_idle("lh_hi");

        push_beat(32'h300, 4'b0010, 1'b1, 32'h3456A500, 32'h0, 0);
        do_req("sb_off1", 1'b1, F3_B, 32'h301, 32'h123456A5, 1'b0, 32'h0, 1'b0, 3);
        wait_idle("sb_off1");

        push_beat(32'h100, 4'b1100, 1'b1, 32'h33440000, 32'h0, 0);
        push_beat(32'h104, 4'b0011, 1'b1, 32'h00001122, 32'h0, 0);
        do_req("sw_split", 1'b1, F3_W, 32'h102, 32'h11223344, 1'b0, 32'h0, 1'b0, 5);
        wait_idle("sw_split");

        push_beat(32'h200, 4'b1000, 1'b0, 32'h0, 32'hAB000000, 0);
        push_beat(32'h204, 4'b0001, 1'b0, 32'h0, 32'h000000CD, 0);
        do_req("lh_split", 1'b0, F3_H, 32'h203, 32'h0, 1'b0, 32'hFFFFCDAB, 1'b1, 5);
        wait_idle("lh_split");

        push_beat(32'h1FC, 4'b1000, 1'b1, 32'hEF000000, 32'h0, 0);
        push_beat(32'h200, 4'b0001, 1'b1, 32'h000000BE, 32'h0, 0);
        do_req("sh_split", 1'b1, F3_H, 32'h1FF, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 5);
        wait_idle("sh_split");

        push_beat(32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 32'h7F000000, 0);
        push_beat(32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h00000001, 0);
        do_req("lh_wrap", 1'b0, F3_H, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0000017F, 1'b1, 5);
        wait_idle("lh_wrap");

        stall_cnt = 5;
        push_beat(32'h300, 4'b1111, 1'b0, 32'h0, 32'h12345678, 0);
        do_req("lw_stall", 1'b0, F3_W, 32'h300, 32'h0, 1'b0, 32'h12345678, 1'b1, 8);
        for (int p = 0; p < 2; p++) begin
            core.lsu_valid = 1'b1; core.lsu_we = 1'b1; core.lsu_addr = 32'h500; core.lsu_wdata = 32'hFFFFFFFF;
            check("busy_ready_low", 32'(core.lsu_ready), 32'd0);
            @(negedge clk);
            core.lsu_valid = 1'b0;
            @(negedge clk);
        end
        wait_idle("lw_stall");

        do_req("ld_illegal", 1'b0, 3'b011, 32'h500, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        wait_idle("ld_illegal");
        do_req("st_illegal", 1'b1, 3'b100, 32'h504, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1);
        wait_idle("st_illegal");

        push_beat(32'h100, 4'b1100, 1'b1, 32'h33440000, 32'h0, 0);
        push_beat(32'h104, 4'b0011, 1'b1, 32'h00001122, 32'h0, 10);
        do_req("rst_mid", 1'b1, F3_W, 32'h102, 32'h11223344, 1'b0, 32'h0, 1'b0, 0);
        for (int k = 0; k < 10 && (cyc - last_c0) < 4; k++) @(negedge clk);
        check("rst_mid_busy", 32'(core.lsu_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(core.lsu_ready), 32'd1);
        check("rst_mid_req", 32'(mem.mem_req), 32'd0);
        check("rst_mid_done", 32'(core.lsu_done), 32'd0);
        check("rst_mid_be", 32'(mem.mem_be), 32'd0);
        check("rst_mid_addr", mem.mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("rst_stray");
        repeat (2) begin
            @(negedge clk);
            check("stray_ready", 32'(core.lsu_ready), 32'd1);
            check("stray_done", 32'(core.lsu_done), 32'd0);
            check("stray_req", 32'(mem.mem_req), 32'd0);
        end

        push_beat(32'h600, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D, 0);
        do_req("lw_after_rst", 1'b0, F3_W, 32'h600, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 3);
        wait_idle("lw_after_rst");

        repeat (3) @(negedge clk);
        check("end_beats_empty", 32'(exp_beats.size()), 32'd0);
        check("end_done_empty", 32'(exp_done.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer between the RV32I core's memory-stage decode and a single-port data memory bus. It accepts one load or store per handshake, generates word-aligned bus beats with byte enables, and splits misaligned halfword and word accesses into two beats. It reassembles and sign- or zero-extends load data, then returns it to the core with a done pulse. It replaces the core's combinational memory read/write select for the multi-cycle datapath.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk  in  1` — clock, rising edge.
- `rst_n  in  1` — asynchronous active-low reset.
- `lsu_valid  in  1` — core request.
- `lsu_ready  out  1` — high only in IDLE; request accepted when `lsu_valid && lsu_ready`.
- `lsu_we  in  1` — 1 = store, 0 = load.
- `lsu_funct3  in  3` — RV32I size/sign field.
- `lsu_addr  in  32` — byte address.
- `lsu_wdata  in  32` — store data, LSB-justified.
- `lsu_done  out  1` — one-cycle completion pulse.
- `lsu_err  out  1` — valid with `lsu_done`; set for illegal `funct3`.
- `lsu_rdata  out  32` — extended load data; valid with `lsu_done`; held until the next done.
- `mem_req  out  1` — bus request.
- `mem_gnt  in  1` — request accepted this cycle.
- `mem_addr  out  32` — word-aligned (`[1:0]`=0).
- `mem_we  out  1` — write beat.
- `mem_be  out  4` — byte enables.
- `mem_wdata  out  32` — lane-positioned write data.
- `mem_rvalid  in  1` — response (read data or write ack). Arrives no earlier than the cycle after `gnt`.
- `mem_rdata  in  32` — read word.

## Operation
- **Legal `funct3`:**
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - **Illegal:** no bus activity; `lsu_done`=1, `lsu_err`=1, `lsu_rdata`=0 in the cycle after accept.
- **Byte masks:** size n = 1, 2 or 4 bytes. `off` = `addr[1:0]`. `mask8` = (n-bit ones) << `off`, 8 bits wide. Split when `mask8[7:4]` ≠ 0.
- **Beat 0:** addr `{addr[31:2],00}`, `be` = `mask8[3:0]`, wdata = low word of (`{32'b0,wdata}` << 8·`off`).
- **Beat 1 (split only):** beat-0 addr + 4, with 32-bit wrap (0xFFFFFFFC → 0x0). `be` = `mask8[7:4]`, wdata = high word of the same shift.
- **Load assembly:** `{beat1,beat0}` >> 8·`off`. Take the low n bytes, then sign-extend (LB, LH) or zero-extend (LBU, LHU, LW). Beat 1 is 0 when not split.
- All request fields are registered at accept; later core inputs are ignored until done.
- **FSM states:**
  - IDLE → ISSUE (legal) or DONE (illegal) on accept.
  - ISSUE: `mem_req`=1 with addr/be/we/wdata stable until `mem_gnt`. On `gnt` → WAIT.
  - WAIT: on `mem_rvalid`, capture the beat. Then → ISSUE for beat 1 if split and this is beat 0; else → DONE.
  - DONE: `lsu_done`=1 for one cycle → IDLE.
- `mem_rvalid` outside WAIT is ignored. Only one transaction is ever outstanding.
- **Reset values:** state IDLE; `lsu_ready`=1; `lsu_done`, `lsu_err`, `mem_req`, `mem_we` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `lsu_rdata` = 0.

## Timing
- Request accepted in cycle 0; `mem_req` rises in cycle 1 (registered).
- With same-cycle `gnt` and `rvalid` one cycle later:
  - Aligned access: `lsu_done` in cycle 3.
  - Split access: `lsu_done` in cycle 5.
- Each cycle of `gnt` or `rvalid` delay adds exactly one cycle.
- `lsu_ready` is low from cycle 1 until the cycle after `lsu_done`. Back-to-back accepts are therefore spaced by at least 4 cycles.
- `rst_n` low at any point: all outputs take their reset values immediately (asynchronously), including mid-beat and between split beats. A partial split store may leave beat 0 written; this is accepted. Responses arriving after reset are ignored.

## Structure
- `lsu_pkg` holds:
  - `funct3` constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum `{IDLE, ISSUE, WAIT, DONE}`.
  - The split/beat flag definitions.
- One combinational sub-module, `lsu_align`, computes byte mask, beat write data, split flag, and load extraction/extension. The FSM and registers stay in `lsu_sequencer`.

## Test plan
- **LW aligned:** LW @0x100, memory word 0xDEADBEEF, immediate `gnt` → one beat with `be`=1111, `lsu_done` in cycle 3, `lsu_rdata`=0xDEADBEEF, `lsu_err`=0.
- **Byte extension:** LB @0x103, word 0x80000000 → `be`=1000, `rdata`=0xFFFFFF80. LBU at the same address → 0x00000080.
- **Split store:** SW @0x102, wdata 0x11223344 → beat 0: addr 0x100, `be`=1100, wdata 0x33440000; beat 1: addr 0x104, `be`=0011, wdata 0x00001122; done in cycle 5.
- **Split load:** LH @0x203, words 0xAB000000 @0x200 and 0x000000CD @0x204 → `rdata`=0xFFFFCDAB.
- **Stall and illegal funct3:**
  - `gnt` withheld 5 cycles → `mem_req`/addr/be stable throughout; `lsu_valid` pulses while busy are not accepted; done at cycle 8.
  - Load with `funct3`=011 → no `mem_req`; `done`=`err`=1 in cycle 1.
- **Reset mid-operation:** `rst_n` pulsed low in WAIT of beat 1 → `mem_req`=0 and `lsu_ready`=1 immediately. A stray `rvalid` afterwards is ignored. The next LW completes normally in 3 cycles.
